regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised successor to the single-cycle core's register file.
- Generalised in data width, register count and number of read ports.
- Adds same-cycle write-to-read bypass, a synchronous clear on reset, and a per-register busy scoreboard for multi-cycle or pipelined writebacks.
- Sits between decode (read ports, issue marking) and writeback (write port). Drives operand values and hazard flags to issue logic.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NREAD, 2, number of independent read ports.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching reads; 0 = reads return the stored value only.
- AW, $clog2(NREGS), register address width (derived; not overridden).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NREAD*AW  packed read addresses; port i at bits [i*AW +: AW].
- rd_data  out  NREAD*XLEN  packed read data; port i at bits [i*XLEN +: XLEN].
- rd_busy  out  NREAD  1 = register on port i has a pending producer.
- we  in  1  write enable (writeback).
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- issue_valid  in  1  an instruction with destination issue_rd is issuing this cycle.
- issue_rd  in  AW  destination register being marked pending.
- busy_cnt  out  AW+1  number of registers currently marked busy.
- issue_hazard  out  1  1 = issue_rd is already busy (WAW); informational, does not block.

Behaviour:
- One clock, clk. rst is synchronous, active-high.
- Reset:
  - At the first rising edge with rst=1, all NREGS entries clear to 0, all busy bits clear to 0, and busy_cnt becomes 0.
  - While rst=1, rst has priority over we and issue_valid.
  - From the cycle after that edge: rd_data reads 0 on every port, rd_busy=0, issue_hazard=0.
- Register 0:
  - Hardwired to zero. Reads always return 0 and rd_busy=0 for address 0.
  - Writes to address 0 are ignored. Issue with issue_rd=0 never sets a busy bit.
- Reads:
  - Combinational, zero latency; each port is independent.
  - Priority: address 0 gives 0. Otherwise, if BYPASS=1 and we=1 and wr_addr equals rd_addr[i], output wr_data. Otherwise output the stored value.
- Writes:
  - At a rising edge with we=1 and wr_addr!=0, the entry takes wr_data.
  - With BYPASS=0, the new value is first visible the cycle after the edge.
- Scoreboard update, per register r != 0, at each rising edge:
  - set = issue_valid && issue_rd==r
  - clr = we && wr_addr==r
  - set=1 gives busy=1; else clr=1 gives busy=0; else busy holds.
  - set and clr on the same register in the same cycle: set wins, because the new producer supersedes the completing one.
  - A write to a non-busy register is legal and leaves busy at 0.
- rd_busy[i]:
  - Equals busy[rd_addr[i]], forced to 0 for address 0.
  - When BYPASS=1, also forced to 0 if a write to that address occurs this cycle, since the data is being forwarded.
- busy_cnt:
  - Registered popcount of the busy bits, updated at the same edge as the busy bits.
  - Range 0..NREGS-1; it cannot wrap because register 0 is never busy.
- issue_hazard:
  - Combinational: issue_valid && issue_rd!=0 && busy[issue_rd].
  - Not cleared by a same-cycle write to issue_rd.
- Other boundary rules:
  - Multiple read ports may address the same register; they return identical data and flags.
  - Reads of undefined entries never return X after the first reset.

Test Plan:
- rst=1 for one cycle, then read addresses 0..31 on both ports -> every rd_data=0, rd_busy=0, busy_cnt=0.
- we=1, wr_addr=5, wr_data=0xDEADBEEF, with rd_addr0=5 in the same cycle -> BYPASS=1: port0 reads 0xDEADBEEF that cycle. BYPASS=0: port0 reads 0 that cycle and 0xDEADBEEF the next.
- we=1, wr_addr=0, wr_data=0x12345678, plus issue_valid=1, issue_rd=0 -> reads of x0 return 0, busy_cnt stays 0.
- issue_valid for rd=3, then rd=7 on consecutive cycles -> busy_cnt counts 1 then 2, and rd_busy=1 when reading address 3. Then we=1, wr_addr=3 -> busy_cnt=1 and reads of address 3 return the written value.
- With reg 9 busy, apply issue_valid=1, issue_rd=9 and we=1, wr_addr=9 in the same cycle -> issue_hazard=1 that cycle; after the edge busy[9] is still 1, busy_cnt is unchanged, and reg 9 holds the new data.
- Mark regs 1..31 busy and write reg 4=0xA5A5A5A5, then assert rst together with we=1, wr_addr=6 -> after the edge all registers read 0 (including regs 4 and 6), busy_cnt=0, rd_busy=0.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with write-to-read bypass and a per-register busy scoreboard.
// Register 0 is hardwired to zero and is never marked busy.
module regfile_mp_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NREAD  = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    output logic [NREAD-1:0]      rd_busy,
    input  logic                  we,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    input  logic                  issue_valid,
    input  logic [AW-1:0]         issue_rd,
    output logic [AW:0]           busy_cnt,
    output logic                  issue_hazard
);

    localparam bit BYP = (BYPASS != 0);

    logic [XLEN-1:0] regs_q [NREGS];
    logic [NREGS-1:0] busy_q, busy_d;
    logic [AW:0]      busy_cnt_q, busy_cnt_d;
    logic             wr_en;

    assign wr_en = we && (wr_addr != '0);

    // Set (new producer issuing) beats clear (writeback completing) on the same register.
    always_comb begin
        // NOTE: every combinational output gets a default first so no latch can be inferred.
        busy_d     = busy_q;
        busy_cnt_d = '0;
        busy_d[0]  = 1'b0;
        for (int unsigned r = 1; r < NREGS; r++) begin
            if (issue_valid && issue_rd == AW'(r)) begin
                busy_d[r] = 1'b1;
            end else if (we && wr_addr == AW'(r)) begin
                busy_d[r] = 1'b0;
            end
        end
        for (int unsigned r = 0; r < NREGS; r++) begin
            busy_cnt_d = busy_cnt_d + {{AW{1'b0}}, busy_d[r]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is cleared on reset so reads never return X afterwards;
            // this costs a reset path on every entry and is intentional here.
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register updating from pre-edge values.
            if (wr_en) begin
                regs_q[wr_addr] <= wr_data;
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic          fwd;
        assign ra  = rd_addr[g*AW +: AW];
        assign fwd = BYP && we && (wr_addr == ra);
        assign rd_data[g*XLEN +: XLEN] = (ra == '0) ? '0 :
                                         fwd        ? wr_data : regs_q[ra];
        assign rd_busy[g] = (ra != '0) && !fwd && busy_q[ra];
    end

    // A same-cycle writeback to issue_rd does not mask the WAW hazard.
    assign issue_hazard = issue_valid && (issue_rd != '0) && busy_q[issue_rd];
    assign busy_cnt     = busy_cnt_q;

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: a reference model pushes expected values to a
// scoreboard queue as stimulus is driven; they are popped and compared when outputs settle.
module tb_regfile_mp_sb;

    localparam int XLEN = 32;
    localparam int NREGS = 32;
    localparam int AW = 5;

    logic            clk;
    logic            rst;
    logic [2*AW-1:0] rd_addr;
    logic [63:0]     rd_data, nb_rd_data;
    logic [1:0]      rd_busy, nb_rd_busy;
    logic            we;
    logic [AW-1:0]   wr_addr;
    logic [31:0]     wr_data;
    logic            issue_valid;
    logic [AW-1:0]   issue_rd;
    logic [AW:0]     busy_cnt, nb_busy_cnt;
    logic            issue_hazard, nb_issue_hazard;

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .busy_cnt(busy_cnt), .issue_hazard(issue_hazard)
    );

    regfile_mp_sb #(.XLEN(XLEN), .NREGS(NREGS), .NREAD(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(nb_rd_data), .rd_busy(nb_rd_busy),
        .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .issue_valid(issue_valid),
        .issue_rd(issue_rd), .busy_cnt(nb_busy_cnt), .issue_hazard(nb_issue_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    logic [31:0] m_regs [NREGS];
    logic        m_busy [NREGS];
    int          m_cnt;

    function automatic logic [31:0] exp_rd(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we && wr_addr == a) return wr_data;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] exp_busy(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return 32'h0;
        if (byp && we && wr_addr == a) return 32'h0;
        return {31'h0, m_busy[a]};
    endfunction

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_checks++;
        if (sb_q.size() == 0) begin
            $error("FAIL scoreboard_empty: observed %h expected <entry>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) n_pass++;
            else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            for (int r = 0; r < NREGS; r++) begin
                m_regs[r] = '0;
                m_busy[r] = 1'b0;
            end
        end else begin
            if (we && wr_addr != 0) m_regs[wr_addr] = wr_data;
            for (int r = 1; r < NREGS; r++) begin
                if (issue_valid && issue_rd == AW'(r)) m_busy[r] = 1'b1;
                else if (we && wr_addr == AW'(r)) m_busy[r] = 1'b0;
            end
        end
        m_cnt = 0;
        for (int r = 0; r < NREGS; r++) m_cnt += int'(m_busy[r]);
    endtask

    // Called just after a falling edge with inputs already driven.
    task automatic step();
        logic [AW-1:0] a0, a1;
        a0 = rd_addr[AW-1:0];
        a1 = rd_addr[2*AW-1:AW];
        push($sformatf("rd_data0@x%0d", a0), exp_rd(a0, 1'b1));
        push($sformatf("rd_data1@x%0d", a1), exp_rd(a1, 1'b1));
        push($sformatf("rd_busy0@x%0d", a0), exp_busy(a0, 1'b1));
        push($sformatf("rd_busy1@x%0d", a1), exp_busy(a1, 1'b1));
        push("busy_cnt", 32'(m_cnt));
        push("issue_hazard", {31'h0, issue_valid && issue_rd != 0 && m_busy[issue_rd]});
        push($sformatf("nb_rd_data0@x%0d", a0), exp_rd(a0, 1'b0));
        push($sformatf("nb_rd_busy0@x%0d", a0), exp_busy(a0, 1'b0));
        #2;
        check(rd_data[31:0]);
        check(rd_data[63:32]);
        check({31'h0, rd_busy[0]});
        check({31'h0, rd_busy[1]});
        check({26'h0, busy_cnt});
        check({31'h0, issue_hazard});
        check(nb_rd_data[31:0]);
        check({31'h0, nb_rd_busy[0]});
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive(input logic r, input logic w, input logic [AW-1:0] wa,
                         input logic [31:0] wd, input logic iv, input logic [AW-1:0] ir,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rst         = r;
        we          = w;
        wr_addr     = wa;
        wr_data     = wd;
        issue_valid = iv;
        issue_rd    = ir;
        rd_addr     = {a1, a0};
    endtask

    initial begin
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, '0);
        @(negedge clk);
        model_edge();

        // Post-reset: every address reads zero on both ports.
        for (int a = 0; a < NREGS; a++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(a), AW'(NREGS - 1 - a));
            step();
        end

        // Same-cycle write to x5: forwarded only with bypass, visible to both next cycle.
        drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, 5'd5, 5'd6);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd5, 5'd5);
        step();

        // x0 ignores writes and issue marking.
        drive(1'b0, 1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 5'd0, 5'd0);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd0, 5'd5);
        step();

        // Issue x3 then x7, then writeback x3.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 5'd3, 5'd7);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 5'd3, 5'd7);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd7);
        step();
        drive(1'b0, 1'b1, 5'd3, 32'h3333_0003, 1'b0, '0, 5'd3, 5'd7);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd3, 5'd3);
        step();

        // x9 busy, then issue and writeback x9 together: set wins, WAW hazard flagged.
        drive(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 5'd9, 5'd0);
        step();
        drive(1'b0, 1'b1, 5'd9, 32'h9999_0009, 1'b1, 5'd9, 5'd9, 5'd7);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd9, 5'd9);
        step();

        // Write to a non-busy register keeps it non-busy.
        drive(1'b0, 1'b1, 5'd12, 32'h0000_00C0, 1'b0, '0, 5'd12, 5'd1);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd12, 5'd12);
        step();

        // Fill the scoreboard: busy_cnt reaches its maximum of NREGS-1.
        for (int r = 1; r < NREGS; r++) begin
            drive(1'b0, 1'b0, '0, '0, 1'b1, AW'(r), AW'(r), 5'd31);
            step();
        end
        drive(1'b0, 1'b1, 5'd4, 32'hA5A5A5A5, 1'b1, 5'd20, 5'd4, 5'd20);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0, '0, 5'd4, 5'd4);
        step();

        // Reset has priority over a concurrent write.
        drive(1'b1, 1'b1, 5'd6, 32'h6666_6666, 1'b1, 5'd2, 5'd4, 5'd6);
        step();
        for (int a = 0; a < NREGS; a += 2) begin
            drive(1'b0, 1'b0, '0, '0, 1'b0, '0, AW'(a), AW'(a + 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
